// File: rtl/subtractor_serial.sv
// Serial subtractor: I_IN1 - I_IN2 with borrow-out, D bits per cycle from the LSB up.
// Latency: N = W/D cycles from acceptance to O_VALID; one IDLE cycle always follows a result handshake.
// Backpressure: O_READY only in IDLE; the result is held in DONE until I_READY.
// Optional build macro SUBTRACTOR_SERIAL_SAT_EN: saturate an underflowing difference to zero.
module subtractor_serial #(
    parameter int W = 16,
    parameter int D = 1
) (
    input  logic         I_CLK,
    input  logic         I_RST_N,
    input  logic [W-1:0] I_IN1,
    input  logic [W-1:0] I_IN2,
    input  logic         I_VALID,
    output logic         O_READY,
    output logic [W:0]   O_OUT,
    output logic         O_VALID,
    input  logic         I_READY
);

    localparam int N  = W / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    res_shift;
    logic            borrow_q, borrow_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [D-1:0]    diff_c;
    logic            bout_c;
    logic            accept;
    logic            last;

    assign accept = (state_q == ST_IDLE) && I_VALID;
    assign last   = (state_q == ST_RUN) && (cnt_q == CW'(N - 1));

    // Ripple chain of D full-subtractor cells fed from the borrow register.
    always_comb begin
        diff_c = '0;
        bout_c = borrow_q;
        for (int i = 0; i < D; i++) begin
            diff_c[i] = a_q[i] ^ b_q[i] ^ bout_c;
            bout_c    = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & bout_c);
        end
    end

    generate
        if (D == W) begin : g_full
            assign res_shift = diff_c;
        end else begin : g_part
            assign res_shift = {diff_c, res_q[W-1:D]};
        end
    endgenerate

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)  state_d = ST_RUN;
            ST_RUN:  if (last)    state_d = ST_DONE;
            ST_DONE: if (I_READY) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        O_READY = (state_q == ST_IDLE);
        O_VALID = (state_q == ST_DONE);
        O_OUT   = {borrow_q, res_q};
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        if (accept) begin
            a_d      = I_IN1;
            b_d      = I_IN2;
            borrow_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == ST_RUN) begin
            a_d      = a_q >> D;
            b_d      = b_q >> D;
            res_d    = res_shift;
            borrow_d = bout_c;
            cnt_d    = cnt_q + 1'b1;
`ifdef SUBTRACTOR_SERIAL_SAT_EN
            if (last && bout_c) begin
                res_d = '0;
            end
`else
`endif
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial: five instances (W=16, D=1,2,4,8,16) checked against an arithmetic model.
module tb_subtractor_serial;

    logic        core_clk = 1'b0;
    logic        arst_n   = 1'b1;
    logic [15:0] in1_dat [5];
    logic [15:0] in2_dat [5];
    logic [4:0]  in_vld;
    logic [4:0]  in_rdy;
    logic [16:0] out_dat [5];
    logic [4:0]  out_vld;
    logic [4:0]  out_rdy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 core_clk = ~core_clk;

    genvar g;
    generate
        for (g = 0; g < 5; g++) begin : g_dut
            subtractor_serial #(.W(16), .D(1 << g)) u_dut (
                .I_CLK   (core_clk),
                .I_RST_N (arst_n),
                .I_IN1   (in1_dat[g]),
                .I_IN2   (in2_dat[g]),
                .I_VALID (in_vld[g]),
                .O_READY (in_rdy[g]),
                .O_OUT   (out_dat[g]),
                .O_VALID (out_vld[g]),
                .I_READY (out_rdy[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b};
`ifdef SUBTRACTOR_SERIAL_SAT_EN
        if (a < b) r = 17'h10000;
`endif
        return r;
    endfunction

    task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input int pre, input int dn, input bit rnd);
        logic [16:0] e;
        int lat;
        e = model(a, b);
        repeat (pre) begin
            in1_dat[k] = 16'($urandom);
            in2_dat[k] = 16'($urandom);
            in_vld[k]  = 1'b0;
            @(posedge core_clk); #1;
        end
        in1_dat[k] = a;
        in2_dat[k] = b;
        in_vld[k]  = 1'b1;
        lat = 0;
        while (!in_rdy[k] && lat < 50) begin
            @(posedge core_clk); #1;
            lat++;
        end
        check("ready_before_accept", 32'(in_rdy[k]), 32'd1);
        @(posedge core_clk); #1;
        in_vld[k]  = 1'b0;
        in1_dat[k] = ~a;
        in2_dat[k] = 16'($urandom);
        lat = 0;
        while (!out_vld[k] && lat < 100) begin
            if (rnd) begin
                in_vld[k]  = 1'($urandom);
                out_rdy[k] = 1'($urandom);
            end
            @(posedge core_clk); #1;
            lat++;
        end
        out_rdy[k] = 1'b0;
        check("latency", 32'(lat), 32'(16 >> k));
        check("result", 32'(out_dat[k]), 32'(e));
        for (int i = 0; i < dn; i++) begin
            in_vld[k] = rnd ? 1'($urandom) : 1'b1;
            @(posedge core_clk); #1;
            check("hold", {13'd0, out_vld[k], in_rdy[k], out_dat[k]}, {13'd0, 1'b1, 1'b0, e});
        end
        out_rdy[k] = 1'b1;
        in_vld[k]  = 1'b1;
        @(posedge core_clk); #1;
        out_rdy[k] = 1'b0;
        check("idle_gap", {30'd0, in_rdy[k], out_vld[k]}, 32'd2);
        in_vld[k]  = 1'b0;
    endtask

    initial begin
        in_vld  = '0;
        out_rdy = '0;
        for (int i = 0; i < 5; i++) begin
            in1_dat[i] = '0;
            in2_dat[i] = '0;
        end
        #2 arst_n = 1'b0;
        #1;
        check("rst_ready", 32'(in_rdy), 32'h1f);
        check("rst_valid", 32'(out_vld), 32'h0);
        check("rst_out0", 32'(out_dat[0]), 32'h0);
        check("rst_out4", 32'(out_dat[4]), 32'h0);
        repeat (2) @(posedge core_clk);
        #1 arst_n = 1'b1;

        run_op(0, 16'h0005, 16'h0003, 0, 10, 1'b1);
        run_op(2, 16'h0003, 16'h0005, 0, 0, 1'b0);
        run_op(0, 16'h0000, 16'hFFFF, 1, 0, 1'b0);
        run_op(0, 16'hFFFF, 16'hFFFF, 0, 1, 1'b0);
        run_op(4, 16'h8000, 16'h0001, 0, 2, 1'b0);
        run_op(3, 16'h0100, 16'h0101, 0, 0, 1'b1);

        // Reset seven cycles into a run: outputs must clear without a clock edge.
        in1_dat[0] = 16'h0F0F;
        in2_dat[0] = 16'h0101;
        in_vld[0]  = 1'b1;
        @(posedge core_clk); #1;
        in_vld[0]  = 1'b0;
        repeat (7) @(posedge core_clk);
        #1 arst_n = 1'b0;
        #1;
        check("midrun_rst_valid", 32'(out_vld[0]), 32'd0);
        check("midrun_rst_out", 32'(out_dat[0]), 32'd0);
        check("midrun_rst_ready", 32'(in_rdy[0]), 32'd1);
        in_vld[0] = 1'b1;
        repeat (2) @(posedge core_clk);
        #1;
        in_vld[0] = 1'b0;
        arst_n    = 1'b1;
        @(posedge core_clk); #1;
        check("no_accept_in_rst", 32'(in_rdy[0]), 32'd1);
        run_op(0, 16'h1234, 16'h0234, 0, 0, 1'b0);

        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 400; n++) begin
                logic [15:0] a, b;
                a = 16'($urandom);
                b = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: b = a;
                    1: a = 16'h0000;
                    2: b = 16'hFFFF;
                    default: ;
                endcase
                run_op(k, a, b, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
